// File: rtl/sub_layer_iter.sv
// Iterative 5-bit S-box layer over the 320-bit state, LANES columns per cycle.
// Optional inverse S-box selected at accept, enabled by `define SUB_LAYER_INV_EN.
module sub_layer_iter #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
`ifdef SUB_LAYER_INV_EN
    input  logic        inv,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sl0,
    output logic [63:0] sl1,
    output logic [63:0] sl2,
    output logic [63:0] sl3,
    output logic [63:0] sl4
);

    localparam int NSLICE = 64 / LANES;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
        LANES != 16 && LANES != 32 && LANES != 64) begin : g_lanes_check
        $error("sub_layer_iter: LANES must be 1, 2, 4, 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [63:0]     w   [5];
    logic [5:0]      base;
    logic [LANES-1:0] cur [5];
    logic [LANES-1:0] nxt [5];
    logic [4:0]      col, sub;
`ifdef SUB_LAYER_INV_EN
    logic            inv_q;
`endif

    function automatic logic [4:0] sbox_fwd(input logic [4:0] v);
        case (v)
            5'h00: sbox_fwd = 5'h04;  5'h01: sbox_fwd = 5'h0b;
            5'h02: sbox_fwd = 5'h1f;  5'h03: sbox_fwd = 5'h14;
            5'h04: sbox_fwd = 5'h1a;  5'h05: sbox_fwd = 5'h15;
            5'h06: sbox_fwd = 5'h09;  5'h07: sbox_fwd = 5'h02;
            5'h08: sbox_fwd = 5'h1b;  5'h09: sbox_fwd = 5'h05;
            5'h0a: sbox_fwd = 5'h08;  5'h0b: sbox_fwd = 5'h12;
            5'h0c: sbox_fwd = 5'h1d;  5'h0d: sbox_fwd = 5'h03;
            5'h0e: sbox_fwd = 5'h06;  5'h0f: sbox_fwd = 5'h1c;
            5'h10: sbox_fwd = 5'h1e;  5'h11: sbox_fwd = 5'h13;
            5'h12: sbox_fwd = 5'h07;  5'h13: sbox_fwd = 5'h0e;
            5'h14: sbox_fwd = 5'h00;  5'h15: sbox_fwd = 5'h0d;
            5'h16: sbox_fwd = 5'h11;  5'h17: sbox_fwd = 5'h18;
            5'h18: sbox_fwd = 5'h10;  5'h19: sbox_fwd = 5'h0c;
            5'h1a: sbox_fwd = 5'h01;  5'h1b: sbox_fwd = 5'h19;
            5'h1c: sbox_fwd = 5'h16;  5'h1d: sbox_fwd = 5'h0a;
            5'h1e: sbox_fwd = 5'h0f;  default: sbox_fwd = 5'h17;
        endcase
    endfunction

`ifdef SUB_LAYER_INV_EN
    function automatic logic [4:0] sbox_inv(input logic [4:0] v);
        case (v)
            5'h00: sbox_inv = 5'h14;  5'h01: sbox_inv = 5'h1a;
            5'h02: sbox_inv = 5'h07;  5'h03: sbox_inv = 5'h0d;
            5'h04: sbox_inv = 5'h00;  5'h05: sbox_inv = 5'h09;
            5'h06: sbox_inv = 5'h0e;  5'h07: sbox_inv = 5'h12;
            5'h08: sbox_inv = 5'h0a;  5'h09: sbox_inv = 5'h06;
            5'h0a: sbox_inv = 5'h1d;  5'h0b: sbox_inv = 5'h01;
            5'h0c: sbox_inv = 5'h19;  5'h0d: sbox_inv = 5'h15;
            5'h0e: sbox_inv = 5'h13;  5'h0f: sbox_inv = 5'h1e;
            5'h10: sbox_inv = 5'h18;  5'h11: sbox_inv = 5'h16;
            5'h12: sbox_inv = 5'h0b;  5'h13: sbox_inv = 5'h11;
            5'h14: sbox_inv = 5'h03;  5'h15: sbox_inv = 5'h05;
            5'h16: sbox_inv = 5'h1c;  5'h17: sbox_inv = 5'h1f;
            5'h18: sbox_inv = 5'h17;  5'h19: sbox_inv = 5'h1b;
            5'h1a: sbox_inv = 5'h04;  5'h1b: sbox_inv = 5'h08;
            5'h1c: sbox_inv = 5'h0f;  5'h1d: sbox_inv = 5'h0c;
            5'h1e: sbox_inv = 5'h10;  default: sbox_inv = 5'h02;
        endcase
    endfunction
`endif

    // Substitute the current slice; column bit 4 (MSB) comes from word 0.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        col  = '0;
        sub  = '0;
        base = 6'(int'(cnt) * LANES);
        for (int j = 0; j < 5; j++) begin
            cur[j] = w[j][base +: LANES];
            nxt[j] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            col = {cur[0][l], cur[1][l], cur[2][l], cur[3][l], cur[4][l]};
`ifdef SUB_LAYER_INV_EN
            sub = inv_q ? sbox_inv(col) : sbox_fwd(col);
`else
            sub = sbox_fwd(col);
`endif
            for (int j = 0; j < 5; j++) nxt[j][l] = sub[4-j];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            // NOTE: the working registers are reset because they drive sl* directly.
            for (int j = 0; j < 5; j++) w[j] <= '0;
`ifdef SUB_LAYER_INV_EN
            inv_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    w[0] <= x0;
                    w[1] <= x1;
                    w[2] <= x2;
                    w[3] <= x3;
                    w[4] <= x4;
                    cnt  <= '0;
`ifdef SUB_LAYER_INV_EN
                    inv_q <= inv;
`endif
                end
                RUN: begin
                    for (int j = 0; j < 5; j++) w[j][base +: LANES] <= nxt[j];
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign sl0 = w[0];
    assign sl1 = w[1];
    assign sl2 = w[2];
    assign sl3 = w[3];
    assign sl4 = w[4];

endmodule

// File: doc/sub_layer_iter.md
# sub_layer_iter

Iterative, parameterised version of the 5-bit S-box substitution layer for the 320-bit permutation state. It processes `LANES` S-box columns per cycle over several cycles, trading latency for area. It sits between the constant-addition and linear-diffusion stages of the round datapath and uses a valid/ready handshake on both sides. An optional inverse mode applies the inverse S-box.

## Interface
Parameters:
- `LANES`, default 8: S-box columns evaluated per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64. Any other value triggers an elaboration error.
- Derived `NSLICE` = 64/`LANES`: cycles per state.

Ports:
- `clk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: input state is valid.
- `in_ready`, output, 1: the block can accept a state.
- `x0`..`x4`, input, 64 each: input state words.
- `inv`, input, 1: selects the inverse S-box. Present only with `SUB_LAYER_INV_EN`.
- `out_valid`, output, 1: `sl0`..`sl4` hold a completed result.
- `out_ready`, input, 1: the downstream stage accepts the result.
- `sl0`..`sl4`, output, 64 each: registered substituted state.

## Operation
- Column i is the 5-bit value {x0[i],x1[i],x2[i],x3[i],x4[i]}, with x0 as the MSB. The output column {sl0[i],sl1[i],sl2[i],sl3[i],sl4[i]} is S(column).
- Forward S-box, listed for inputs 0x00..0x1F: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- The implementation may use the equivalent boolean form or a lookup table. Results must be bit-identical.
- Inverse S-box, when enabled: S⁻¹(S(v)) = v for all 32 values, with a table derived from the forward table.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, load x0..x4 into five 64-bit working registers, clear the slice counter, latch `inv` if present, and go to RUN.
  - RUN: each cycle, substitute columns [k·LANES+LANES-1 : k·LANES] for slice k, in place, and increment k. After slice `NSLICE`-1, go to DONE.
  - DONE: `out_valid`=1, and `sl0`..`sl4` equal the working registers. On `out_ready`, go to IDLE.
- `in_ready` is combinational from the state (IDLE only). No input is accepted in RUN or DONE, and `in_valid` is ignored there.
- `sl*` outputs are driven directly from the working registers. They hold their value in IDLE until the next load, but are meaningful only while `out_valid`=1.
- Input values are sampled only on the accept edge. Later changes to x*/`inv` do not affect the current operation.
- The slice counter is ceil(log2(`NSLICE`)) bits, minimum 1.
  - With `LANES`=64, RUN lasts exactly one cycle.
  - The counter never wraps inside RUN.

## Timing
- Reset values:
  - state IDLE, so `in_ready`=1.
  - `out_valid`=0.
  - working registers and `sl0`..`sl4` = 0.
  - slice counter = 0.
- Accept on edge T (`in_valid`&&`in_ready`): in RUN for edges T+1..T+`NSLICE`. `out_valid` rises after edge T+`NSLICE`.
- Latency from accept to `out_valid` is `NSLICE` cycles. With immediate `out_ready`, the next accept is possible 1 cycle after the output handshake. Throughput is one state per `NSLICE`+2 cycles.
- Holding `out_ready`=0 keeps DONE, `out_valid` and `sl*` stable indefinitely.
- Reset asserted in any state, including mid-RUN, takes effect on the next edge: the operation is aborted, all outputs return to reset values, and no partial result is ever flagged valid.
- Reset has priority over a simultaneous accept or output handshake.

## Configuration
- `SUB_LAYER_INV_EN` defined:
  - The `inv` port exists and is sampled at accept.
  - `inv`=1 applies S⁻¹ to every column of that state; `inv`=0 applies S.
- Undefined:
  - No `inv` port and no inverse logic.
  - Forward S-box only; behaviour is identical to defined-with-`inv`=0.

## Test plan
- Reset, then all x*=0 with `LANES`=8: `out_valid` after exactly 8 cycles; sl0=sl1=sl3=sl4=0 and sl2=64'hFFFF_FFFF_FFFF_FFFF.
- All x*=64'hFFFF_FFFF_FFFF_FFFF: sl0=sl2=sl3=sl4=all-ones and sl1=0 (column 1F→17). Repeat for `LANES`=1, 16 and 64 with latencies 64, 4 and 1.
- Exhaustive column check: column i = i mod 32 for i=0..63. Each output column equals the table entry, confirming the slice ordering.
- Backpressure: hold `out_ready`=0 for 20 cycles. Outputs stay stable, `in_ready`=0, and `in_valid` pulses are ignored. Releasing `out_ready` returns to IDLE next cycle.
- Assert `rst` for one cycle at RUN slice 3. Outputs go to 0 and `out_valid`=0; a fresh accept then completes correctly.
- With `SUB_LAYER_INV_EN`: inverse on sl2=all-ones with others 0 returns all zeros. Forward followed by inverse on 100 random states returns the original state.
